// File: rtl/hand_unpack_pkg.sv
// ---------------------------------------------------------------------------
// hand_pkg
// Shared constants and types for the wide/narrow beat converters. The reader
// side (hand_unpack) and its writer-side packer counterpart both take their
// default beat widths from here, so the two always agree.
// No ports: package only.
// ---------------------------------------------------------------------------
package hand_pkg;

   // Default ingress (wide) and egress (narrow) beat widths in bits
   localparam int HAND_IN_WIDTH  = 128;
   localparam int HAND_OUT_WIDTH = 32;

   // IDLE: nothing held. EMIT: a wide beat is held and lanes are pending.
   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } handState_e;

endpackage

// File: rtl/hand_unpack_if.sv
// ---------------------------------------------------------------------------
// hand_unpack_if
// Bundles the ingress (wide) and egress (narrow) valid/ready channels of the
// unpacker into one interface.
//   in_valid/in_data/in_cnt/in_last/in_ready : wide ingress channel
//   out_valid/out_data/out_last/out_ready    : narrow egress channel
// Modports:
//   slave  : the unpacker's view (consumes ingress, produces egress)
//   master : the surrounding logic's view (produces ingress, consumes egress)
// ---------------------------------------------------------------------------
interface hand_unpack_if
   import hand_pkg::*;
#(
   parameter int IN_WIDTH  = HAND_IN_WIDTH,
   parameter int OUT_WIDTH = HAND_OUT_WIDTH
);

   localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_WD = $clog2(RATIO) + 1;

   logic                 in_valid;
   logic [IN_WIDTH-1:0]  in_data;
   logic [CNT_WD-1:0]    in_cnt;
   logic                 in_last;
   logic                 in_ready;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;
   logic                 out_ready;

   modport slave (
      input  in_valid, in_data, in_cnt, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_cnt, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/hand_unpack.sv
// ---------------------------------------------------------------------------
// hand_unpack
// Splits each accepted wide beat (IN_WIDTH bits) into up to RATIO narrow beats
// (OUT_WIDTH bits), lane 0 first, one narrow beat per cycle while the egress
// side is ready. Only the lowest "effective count" lanes are sent; out_last
// marks the final lane of a beat that carried in_last.
// Ports:
//   clk  : single clock, everything changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : hand_unpack_if.slave, ingress + egress valid/ready channels
// ---------------------------------------------------------------------------
module hand_unpack
   import hand_pkg::*;
#(
   parameter int IN_WIDTH  = HAND_IN_WIDTH,
   parameter int OUT_WIDTH = HAND_OUT_WIDTH
) (
   input logic        clk,
   input logic        rst,
   hand_unpack_if.slave bus
);

   localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_WD = $clog2(RATIO) + 1;
   localparam logic [CNT_WD-1:0] RATIO_CNT = CNT_WD'(RATIO);
   localparam logic [CNT_WD-1:0] ONE_CNT   = CNT_WD'(1);

   handState_e           r_state;
   logic [CNT_WD-1:0]    r_idx;
   logic [CNT_WD-1:0]    r_cnt;
   logic                 r_last;
   logic [IN_WIDTH-1:0]  r_data;
   logic                 r_outValid;
   logic                 r_outLast;
   logic [OUT_WIDTH-1:0] r_outData;

   logic [CNT_WD-1:0]    w_effCnt;
   logic [CNT_WD-1:0]    w_idxNext;
   logic                 w_atLast;
   logic                 w_inReady;
   logic                 w_accept;
   logic                 w_fire;
   logic [OUT_WIDTH-1:0] w_nextLane;

   // A count of zero, or one larger than the beat can hold, both mean
   // "every lane is valid".
   always_comb begin
      w_effCnt = bus.in_cnt;
      if (bus.in_cnt == '0 || bus.in_cnt > RATIO_CNT) begin
         w_effCnt = RATIO_CNT;
      end
   end

   // Handshake decode. A new wide beat may be taken either when nothing is
   // held, or in the very cycle the final held lane leaves, which is what
   // lets consecutive wide beats stream without a dead cycle.
   assign w_idxNext = r_idx + ONE_CNT;
   assign w_atLast  = (r_idx == r_cnt - ONE_CNT);
   assign w_inReady = (r_state == IDLE) || (bus.out_ready && w_atLast);
   assign w_accept  = bus.in_valid && w_inReady;
   assign w_fire    = r_outValid && bus.out_ready;

   // Lane multiplexer for the lane that follows the one currently on the
   // output; it is loaded into the output register when the current lane
   // is consumed, so out_data stays a plain flop.
   always_comb begin
      w_nextLane = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (w_idxNext == CNT_WD'(k)) begin
            w_nextLane = r_data[k*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   // Control FSM with registered out_valid/out_last. Acceptance wins over the
   // "last lane consumed" return to IDLE, since both can happen together.
   // Reset throws away whatever lanes were still pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_cnt      <= RATIO_CNT;
         r_last     <= 1'b0;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
      end else if (w_accept) begin
         r_state    <= EMIT;
         r_idx      <= '0;
         r_cnt      <= w_effCnt;
         r_last     <= bus.in_last;
         r_outValid <= 1'b1;
         r_outLast  <= bus.in_last && (w_effCnt == ONE_CNT);
      end else if (w_fire) begin
         if (w_atLast) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
         end else begin
            r_idx     <= w_idxNext;
            r_outLast <= r_last && (w_idxNext == r_cnt - ONE_CNT);
         end
      end
   end

   // Data path holding registers. These never need a reset: their contents
   // are only observed while r_outValid is set, and that is cleared by reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_data    <= bus.in_data;
         r_outData <= bus.in_data[OUT_WIDTH-1:0];
      end else if (w_fire && !w_atLast) begin
         r_outData <= w_nextLane;
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.out_data  = r_outData;
   assign bus.out_last  = r_outLast;

endmodule
